mru_button_front: RTL and testbench
===================================

Name: mru_button_front

Overview:
- Input-side producer for the MRU tracker's button interface.
- Synchronizes and debounces N_BTN raw push-buttons, and detects presses.
- Queues one event per press in a small FIFO and presents them with a valid/ready handshake.
- Replaces direct sampling of the raw b1..b5 buttons, so each physical press yields exactly one "use" event.

Parameters:
- N_BTN, 5, number of buttons.
- DEBOUNCE_CYCLES, 1000000, cycles of steady disagreement needed before the stable level flips (10 ms at 100 MHz).
- FIFO_DEPTH, 4, event queue entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high, sampled on the rising edge of clk.
- btn_raw  in  N_BTN  asynchronous raw button levels; 1 = pressed.
- evt_valid  out  1  event available at the FIFO head.
- evt_ready  in  1  consumer accepts the head event this cycle.
- evt_idx  out  3  button index of the head event, 0..N_BTN-1.
- evt_onehot  out  N_BTN  one-hot decode of evt_idx; all zero when evt_valid=0.
- evt_release  out  1  1 = release event; tied 0 unless the optional feature is compiled in.
- btn_level  out  N_BTN  debounced stable levels.
- overflow  out  1  sticky flag: a press was merged into an already-pending one.

Behaviour:
- Reset (rst=1 at a clk edge): sync flops, stable levels, debounce counters, pending masks, FIFO pointers and overflow all go to 0.
  - Resulting outputs: evt_valid=0, evt_idx=0, evt_onehot=0, btn_level=0, overflow=0.
  - Reset mid-operation discards queued and pending events. A button held through reset reports a press only after a full debounce from released.
- Sync: two flops per button.
- Debounce, per button:
  - If synced != stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable flips and the counter clears.
  - If synced == stable, the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never flip stable.
  - Counter width: $clog2(DEBOUNCE_CYCLES).
- Edge: a 0->1 transition of stable asserts a one-cycle press strobe, which sets that button's pending bit.
- Arbiter:
  - Each cycle, if the pending mask is nonzero and (FIFO not full, or a pop occurs this cycle), push the lowest set index and clear its bit.
  - One push per cycle. Simultaneous presses drain lowest index first, one per cycle.
- Merge/overflow:
  - A press strobe on a button whose pending bit is already set and not being cleared this cycle sets overflow. The event is merged, never duplicated.
  - When the FIFO is full, pending bits hold; no event is lost unless it is merged.
  - overflow clears only on rst.
- FIFO: show-ahead. evt_valid = not empty; pop on evt_valid && evt_ready. Push and pop in the same cycle are legal when full.
- Handshake: the head event is stable while evt_valid=1 && evt_ready=0. evt_ready while empty is ignored.
- Latency: btn_raw held high from the sampling edge k gives evt_valid=1 at edge k+DEBOUNCE_CYCLES+4, provided the queue is empty and nothing is pending.

Optional Feature:
- Macro: MRU_BTN_RELEASE_EN.
- Defined:
  - A 1->0 transition of stable sets a second release-pending mask.
  - The arbiter serves all press-pending bits before release-pending bits, lowest index first within each class.
  - Release events are pushed with evt_release=1.
  - Merging into an already-set release bit also sets overflow.
- Undefined: no release logic; evt_release is constant 0.

Decomposition:
- Package mru_pkg:
  - N_BTN=5.
  - IDX_W=3.
  - Typedef mru_evt_t, a packed struct {logic release; logic [IDX_W-1:0] idx}.
  - Function idx_to_onehot.
- Sub-module mru_debounce (one instance per button):
  - Contains the 2-flop sync, counter and stable register.
  - Outputs level, press strobe and release strobe.
- FIFO and arbiter stay inline.

Test Plan (DEBOUNCE_CYCLES=8, FIFO_DEPTH=4):
- Single press: btn_raw[2]=1 from edge 10, evt_ready=1 -> evt_valid=1 only at edge 22 with evt_idx=2, evt_onehot=5'b00100; one event total.
- Bounce: btn_raw[0] toggles every 3 cycles for 30 cycles, then is held 1 -> btn_level[0] rises once; exactly one event, idx 0.
- Simultaneous: btn_raw[4]/[1]/[3] all rise at the same edge, evt_ready=0 -> FIFO holds idx 1, 3, 4 in that order on consecutive cycles. Then evt_ready=1 -> they are popped 1, 3, 4.
- Backpressure/overflow: evt_ready=0. Five distinct buttons are each pressed once -> 4 events queue and the fifth is held pending. Button 4 is then pressed again before the pending bit drains -> overflow=1. Draining then yields exactly 5 events.
- Reset mid-operation: 3 events queued, rst pulsed for 1 cycle -> next edge: evt_valid=0, overflow=0, btn_level=0. A held button re-reports after 12 cycles.
- With MRU_BTN_RELEASE_EN: press, then release of button 1 -> events (idx1, release0) then (idx1, release1). Without the macro, evt_release stays 0 throughout.

Source files
------------

// File: rtl/mru_pkg.sv
// Shared types and helpers for the MRU button front end: event record,
// index width and small mask utilities used by the arbiter and output decode.
package mru_pkg;

  localparam int N_BTN = 5;
  localparam int IDX_W = 3;

  // Queued event; is_release is only ever set when release events are compiled in.
  typedef struct packed {
    logic             is_release;
    logic [IDX_W-1:0] idx;
  } mru_evt_t;

  function automatic logic [N_BTN-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    idx_to_onehot = '0;
    for (int i = 0; i < N_BTN; i++) begin
      idx_to_onehot[i] = (idx == IDX_W'(i));
    end
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_BTN-1:0] mask);
    lowest_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (mask[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/mru_button_front_if.sv
// Event channel from the button front end to the MRU tracker.
// Valid/ready: an event transfers on every clk edge where evt_valid && evt_ready;
// while evt_valid=1 and evt_ready=0 the head event holds steady; ready while not valid is ignored.
interface mru_button_front_if;
  import mru_pkg::*;

  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_idx;
  logic [N_BTN-1:0] evt_onehot;
  logic             evt_release;

  modport master (output evt_valid, evt_idx, evt_onehot, evt_release, input evt_ready);
  modport slave  (input evt_valid, evt_idx, evt_onehot, evt_release, output evt_ready);
endinterface

// File: rtl/mru_debounce.sv
// One button: two-flop synchronizer, disagreement counter and stable level,
// plus registered one-cycle press (and, with MRU_BTN_RELEASE_EN, release) strobes.
module mru_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
`ifdef MRU_BTN_RELEASE_EN
  output logic rel,
`endif
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic             stable, stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
`ifdef MRU_BTN_RELEASE_EN
      rel      <= 1'b0;
`endif
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
`ifdef MRU_BTN_RELEASE_EN
      rel      <= ~stable & stable_d;
`endif
      // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= ~stable;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/mru_button_front.sv
// Debounced push-button front end: one event per press, queued in a show-ahead FIFO.
// Optional release events are compiled in with MRU_BTN_RELEASE_EN.
module mru_button_front
  import mru_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BTN-1:0]    btn_raw,
  mru_button_front_if.master  evt,
  output logic [N_BTN-1:0]    btn_level,
  output logic                overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [N_BTN-1:0] press_stb, pend_press, clr_press;
  logic             press_merge;
`ifdef MRU_BTN_RELEASE_EN
  logic [N_BTN-1:0] rel_stb, pend_rel, clr_rel;
  logic             rel_merge;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    mru_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
`ifdef MRU_BTN_RELEASE_EN
      .rel   (rel_stb[i]),
`endif
      .level (btn_level[i]),
      .press (press_stb[i])
    );
  end

  // FIFO pointers carry one extra wrap bit to tell full from empty.
  mru_evt_t        mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full, pop, push;
  mru_evt_t        push_evt, head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = evt.evt_valid && evt.evt_ready;
  assign head  = mem[rd_ptr[AW-1:0]];

  // Presses win over releases; lowest index first within each class.
  always_comb begin
    push      = 1'b0;
    push_evt  = '0;
    clr_press = '0;
`ifdef MRU_BTN_RELEASE_EN
    clr_rel   = '0;
`endif
    if (!full || pop) begin
      if (|pend_press) begin
        push         = 1'b1;
        push_evt.idx = lowest_idx(pend_press);
        clr_press    = idx_to_onehot(push_evt.idx);
      end
`ifdef MRU_BTN_RELEASE_EN
      else if (|pend_rel) begin
        push                = 1'b1;
        push_evt.is_release = 1'b1;
        push_evt.idx        = lowest_idx(pend_rel);
        clr_rel             = idx_to_onehot(push_evt.idx);
      end
`endif
    end
  end

  assign press_merge = |(press_stb & pend_press & ~clr_press);
`ifdef MRU_BTN_RELEASE_EN
  assign rel_merge   = |(rel_stb & pend_rel & ~clr_rel);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pend_press <= '0;
      overflow   <= 1'b0;
`ifdef MRU_BTN_RELEASE_EN
      pend_rel   <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      pend_press <= (pend_press & ~clr_press) | press_stb;
      if (press_merge) overflow <= 1'b1;
`ifdef MRU_BTN_RELEASE_EN
      pend_rel <= (pend_rel & ~clr_rel) | rel_stb;
      if (rel_merge) overflow <= 1'b1;
`endif
    end
  end

  // Storage needs no reset: it is only visible through the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_evt;
  end

  assign evt.evt_valid   = !empty;
  assign evt.evt_idx     = empty ? '0 : head.idx;
  assign evt.evt_onehot  = empty ? '0 : idx_to_onehot(head.idx);
  assign evt.evt_release = !empty && head.is_release;

endmodule

// File: tb/tb_mru_button_front.sv
// Bench for mru_button_front: directed scenarios plus random button activity,
// compared every cycle with an event-level reference model.
module tb_mru_button_front;
  import mru_pkg::*;

  localparam int D     = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic             overflow;

  mru_button_front_if bus ();

  mru_button_front #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .evt       (bus.master),
    .btn_level (btn_level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_pops = 0;
  logic [IDX_W:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: sample history per button, pending sets, and the expected event queue.
  logic [N_BTN-1:0] m_s1, m_s2, m_stable, m_rise0, m_rise1, m_pend;
`ifdef MRU_BTN_RELEASE_EN
  logic [N_BTN-1:0] m_fall0, m_fall1, m_pend_rel;
`endif
  bit               m_ovf;
  bit               hist[N_BTN][$];
  logic [IDX_W:0]   exp_q[$];

  function automatic int first_set(input logic [N_BTN-1:0] m);
    for (int i = 0; i < N_BTN; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    logic [N_BTN-1:0] new_stable;
    bit room, all_diff;
    int sel;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise0 = '0; m_rise1 = '0; m_pend = '0;
`ifdef MRU_BTN_RELEASE_EN
      m_fall0 = '0; m_fall1 = '0; m_pend_rel = '0;
`endif
      m_ovf = 0;
      exp_q.delete();
      for (int b = 0; b < N_BTN; b++) hist[b].delete();
      return;
    end
    room = (exp_q.size() < DEPTH) || (exp_q.size() > 0 && bus.evt_ready);
    if (exp_q.size() > 0 && bus.evt_ready) void'(exp_q.pop_front());
    sel = first_set(m_pend);
    if (room && sel >= 0) begin
      exp_q.push_back({1'b0, IDX_W'(sel)});
      m_pend[sel] = 1'b0;
    end
`ifdef MRU_BTN_RELEASE_EN
    else if (room && first_set(m_pend_rel) >= 0) begin
      sel = first_set(m_pend_rel);
      exp_q.push_back({1'b1, IDX_W'(sel)});
      m_pend_rel[sel] = 1'b0;
    end
    if ((m_fall1 & m_pend_rel) != '0) m_ovf = 1;
    m_pend_rel |= m_fall1;
`endif
    if ((m_rise1 & m_pend) != '0) m_ovf = 1;
    m_pend |= m_rise1;
    new_stable = m_stable;
    for (int b = 0; b < N_BTN; b++) begin
      hist[b].push_back(m_s2[b]);
      if (hist[b].size() > D) void'(hist[b].pop_front());
      if (hist[b].size() == D) begin
        all_diff = 1;
        for (int j = 0; j < hist[b].size(); j++) if (hist[b][j] == m_stable[b]) all_diff = 0;
        if (all_diff) new_stable[b] = ~m_stable[b];
      end
    end
    m_rise1 = m_rise0;
    m_rise0 = new_stable & ~m_stable;
`ifdef MRU_BTN_RELEASE_EN
    m_fall1 = m_fall0;
    m_fall0 = ~new_stable & m_stable;
`endif
    m_stable = new_stable;
    m_s2 = m_s1;
    m_s1 = btn_raw;
  endtask

  task automatic check_outputs();
    logic [IDX_W:0] h;
    bit v;
    v = exp_q.size() > 0;
    h = v ? exp_q[0] : '0;
    check("evt_valid", 32'(bus.evt_valid), 32'(v));
    check("evt_idx", 32'(bus.evt_idx), 32'(h[IDX_W-1:0]));
    check("evt_onehot", 32'(bus.evt_onehot), v ? (32'd1 << h[IDX_W-1:0]) : 32'd0);
    check("evt_release", 32'(bus.evt_release), 32'(h[IDX_W]));
    check("btn_level", 32'(btn_level), 32'(m_stable));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cycle();
    if (bus.evt_valid && bus.evt_ready) begin
      got_q.push_back({bus.evt_release, bus.evt_idx});
      if (!bus.evt_release) dut_pops++;
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int lat, p0;
    btn_raw = '0;
    bus.evt_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    run(2);
    check("reset_valid", 32'(bus.evt_valid), 32'd0);
    check("reset_idx", 32'(bus.evt_idx), 32'd0);
    check("reset_onehot", 32'(bus.evt_onehot), 32'd0);
    check("reset_level", 32'(btn_level), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Single press on button 2 and its latency.
    bus.evt_ready = 1'b1;
    run(8);
    p0 = dut_pops;
    lat = -1;
    btn_raw[2] = 1'b1;
    for (int t = 0; t < 24; t++) begin
      cycle();
      if (bus.evt_valid && lat < 0) lat = t;
    end
    check("press_latency", 32'(lat), 32'(D + 4));
    check("single_count", 32'(dut_pops - p0), 32'd1);
    btn_raw[2] = 1'b0;
    run(16);

    // Bouncing contact on button 0.
    p0 = dut_pops;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) btn_raw[0] = ~btn_raw[0];
      cycle();
    end
    btn_raw[0] = 1'b1;
    run(18);
    check("bounce_count", 32'(dut_pops - p0), 32'd1);
    btn_raw[0] = 1'b0;
    run(16);

    // Simultaneous presses drain lowest index first.
    bus.evt_ready = 1'b0;
    btn_raw = 5'b11010;
    run(16);
    got_q.delete();
    bus.evt_ready = 1'b1;
    run(5);
    check("simul_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() >= 3) begin
      check("simul_first", 32'(got_q[0]), 32'd1);
      check("simul_second", 32'(got_q[1]), 32'd3);
      check("simul_third", 32'(got_q[2]), 32'd4);
    end
    btn_raw = '0;
    run(16);

    // Backpressure: four queue, the fifth waits, a repeat press merges.
    bus.evt_ready = 1'b0;
    p0 = dut_pops;
    for (int b = 0; b < N_BTN; b++) begin
      btn_raw[b] = 1'b1;
      run(12);
      btn_raw[b] = 1'b0;
      run(12);
    end
    check("bp_no_overflow_yet", 32'(overflow), 32'd0);
    btn_raw[4] = 1'b1;
    run(14);
    check("bp_overflow", 32'(overflow), 32'd1);
    bus.evt_ready = 1'b1;
    btn_raw = '0;
    run(30);
    check("bp_drain_count", 32'(dut_pops - p0), 32'd5);

    // Reset with events queued; a held button re-reports after a full debounce.
    bus.evt_ready = 1'b0;
    btn_raw = 5'b00111;
    run(14);
    btn_raw = 5'b00001;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_mid_valid", 32'(bus.evt_valid), 32'd0);
    check("rst_mid_overflow", 32'(overflow), 32'd0);
    check("rst_mid_level", 32'(btn_level), 32'd0);
    bus.evt_ready = 1'b1;
    lat = -1;
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (bus.evt_valid && lat < 0) lat = t;
    end
    check("rst_mid_relatency", 32'(lat), 32'(D + 4));
    btn_raw = '0;
    run(16);

`ifdef MRU_BTN_RELEASE_EN
    got_q.delete();
    btn_raw[1] = 1'b1;
    run(16);
    btn_raw[1] = 1'b0;
    run(16);
    check("rel_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      check("rel_press_evt", 32'(got_q[0]), 32'h01);
      check("rel_release_evt", 32'(got_q[1]), 32'h09);
    end
`endif

    // Random button activity with random backpressure and rare resets.
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < N_BTN; b++) begin
        if ($urandom_range(0, 11) == 0) btn_raw[b] = ~btn_raw[b];
      end
      bus.evt_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    btn_raw = '0;
    bus.evt_ready = 1'b1;
    run(40);
    check("final_empty", 32'(bus.evt_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
